// File: rtl/apb_master_pkg.sv
// rtl/apb_master_pkg.sv - shared state encoding and default sizes for the round-robin APB master
package apb_master_pkg;

    localparam int NREQ_DEF    = 2;
    localparam int ADDR_DEF    = 10;
    localparam int DATA_DEF    = 32;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RDATA
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin winner select with wrap-around search from a rotating pointer
module rr_arbiter
    import apb_master_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            pclk,
    input  logic            preset_n,
    input  logic [NREQ-1:0] req_vec,
    input  logic            grant,
    output logic [IW-1:0]   winner,
    output logic            any_req
);

    logic [IW-1:0] ptr;
    int            j;

    // Walk offsets from high to low so the lowest offset from ptr wins last.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        j       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = (int'(ptr) + k) % NREQ;
            if (req_vec[j]) begin
                winner  = IW'(j);
                any_req = 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            ptr <= '0;
        end else if (grant && any_req) begin
            ptr <= (int'(winner) == NREQ - 1) ? '0 : winner + 1'b1;
        end
    end

endmodule

// File: rtl/apb_rr_master.sv
// rtl/apb_rr_master.sv - shares one APB slave among NREQ requesters with round-robin grant and timeout abort
module apb_rr_master
    import apb_master_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int ADDR    = ADDR_DEF,
    parameter int DATA    = DATA_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                 pclk,
    input  logic                 preset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_write,
    input  logic [NREQ*ADDR-1:0] req_addr,
    input  logic [NREQ*DATA-1:0] req_wdata,
    output logic [NREQ-1:0]      done,
    output logic [DATA-1:0]      rdata,
    output logic                 err,
    output logic                 psel,
    output logic                 penable,
    output logic                 pwrite,
    output logic [ADDR-1:0]      paddr,
    output logic [DATA-1:0]      pwdata,
    input  logic [DATA-1:0]      prdata,
    input  logic                 pready
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    state_t          state;
    logic [IW-1:0]   idx;
    logic [IW-1:0]   winner;
    logic            any_req;
    logic [CW-1:0]   wait_cnt;
    logic [NREQ-1:0] pend;

    // A requester whose done is high this cycle counts as already served.
    assign pend = req & ~done;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .pclk     (pclk),
        .preset_n (preset_n),
        .req_vec  (pend),
        .grant    (state == IDLE),
        .winner   (winner),
        .any_req  (any_req)
    );

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state    <= IDLE;
            idx      <= '0;
            wait_cnt <= '0;
            psel     <= 1'b0;
            penable  <= 1'b0;
            pwrite   <= 1'b0;
            paddr    <= '0;
            pwdata   <= '0;
            done     <= '0;
            err      <= 1'b0;
            rdata    <= '0;
        end else begin
            done <= '0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        idx    <= winner;
                        pwrite <= req_write[winner];
                        paddr  <= req_addr[int'(winner)*ADDR +: ADDR];
                        pwdata <= req_wdata[int'(winner)*DATA +: DATA];
                        psel   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    penable  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        if (pwrite) begin
                            done[idx] <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            state <= RDATA;
                        end
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        psel      <= 1'b0;
                        penable   <= 1'b0;
                        done[idx] <= 1'b1;
                        err       <= 1'b1;
                        state     <= IDLE;
                    end else if (wait_cnt != CW'(TIMEOUT)) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                RDATA: begin
                    // The slave registered prdata on the edge that closed ACCESS.
                    rdata     <= prdata;
                    done[idx] <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_rr_master.sv
// tb/tb_apb_rr_master.sv - randomized directed bench for apb_rr_master against a transaction-level model
module tb_apb_rr_master;

    localparam int NREQ    = 4;
    localparam int ADDR    = 10;
    localparam int DATA    = 32;
    localparam int TIMEOUT = 16;

    logic                 pclk = 1'b0;
    logic                 preset_n;
    logic [NREQ-1:0]      req, req_write, done;
    logic [NREQ*ADDR-1:0] req_addr;
    logic [NREQ*DATA-1:0] req_wdata;
    logic [DATA-1:0]      rdata, pwdata, prdata;
    logic                 err, psel, penable, pwrite, pready;
    logic [ADDR-1:0]      paddr;

    apb_rr_master #(.NREQ(NREQ), .ADDR(ADDR), .DATA(DATA), .TIMEOUT(TIMEOUT)) dut (
        .pclk      (pclk),
        .preset_n  (preset_n),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    int              t = 0;
    int              ptr = 0;
    bit              in_flight = 0;
    int              g_tick = 0, who = 0, n_acc = 0, done_d = 0;
    bit              m_wr, m_to;
    logic [ADDR-1:0] m_addr;
    logic [DATA-1:0] m_data;
    logic [DATA-1:0] ref_rdata = '0;
    logic [NREQ-1:0] mdone = '0;
    logic [DATA-1:0] ref_mem [int];
    logic [DATA-1:0] slave_mem [int];
    int              remaining [NREQ];
    int              dut_done_cnt [NREQ];
    int              first_dut_done = -1;
    int              slv_wait = 0, acc_cnt = 0, wait_mode = 0;
    bit              pend_rd = 0;
    logic [ADDR-1:0] rd_addr;
    bit              ov_en = 0, ov_wr = 0;
    logic [ADDR-1:0] ov_addr;
    logic [DATA-1:0] ov_data;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DATA-1:0] ref_get(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : '0;
    endfunction

    function automatic logic [DATA-1:0] slave_get(input int a);
        return slave_mem.exists(a) ? slave_mem[a] : '0;
    endfunction

    // Expected bus/completion behaviour derived from the grant tick and the planned wait count.
    task automatic tick();
        int d;
        bit act;
        logic [NREQ-1:0] edone;
        bit eerr;
        @(negedge pclk);
        t++;
        d     = t - g_tick;
        act   = in_flight && d >= 1 && d <= 1 + n_acc;
        edone = '0;
        eerr  = 1'b0;
        if (in_flight && d == done_d) begin
            edone[who] = 1'b1;
            eerr       = m_to;
            if (!m_wr && !m_to) ref_rdata = ref_get(int'(m_addr));
        end
        check("psel", psel, act);
        check("penable", penable, act && d >= 2);
        if (act) begin
            check("paddr", paddr, m_addr);
            check("pwrite", pwrite, m_wr);
            check("pwdata", pwdata, m_data);
        end
        check("done", done, edone);
        check("err", err, eerr);
        check("rdata", rdata, ref_rdata);
        for (int i = 0; i < NREQ; i++) begin
            if (done[i] === 1'b1) begin
                dut_done_cnt[i]++;
                if (first_dut_done < 0) first_dut_done = i;
            end
        end
        mdone = edone;
    endtask

    task automatic complete();
        if (mdone != '0) begin
            if (m_wr && !m_to) ref_mem[int'(m_addr)] = m_data;
            in_flight = 0;
            req[who]  = 1'b0;
            remaining[who]--;
        end
    endtask

    task automatic arm();
        for (int i = 0; i < NREQ; i++) begin
            if (!req[i] && remaining[i] > 0) begin
                req[i] = 1'b1;
                if (ov_en) begin
                    req_write[i]               = ov_wr;
                    req_addr[i*ADDR +: ADDR]   = ov_addr;
                    req_wdata[i*DATA +: DATA]  = ov_data;
                end else begin
                    req_write[i]               = 1'($urandom_range(0, 1));
                    req_addr[i*ADDR +: ADDR]   = ADDR'($urandom_range(0, 15) << 6);
                    req_wdata[i*DATA +: DATA]  = $urandom;
                end
            end
        end
    endtask

    task automatic grant();
        logic [NREQ-1:0] p;
        int w;
        if (in_flight) return;
        p = req & ~mdone;
        if (p == '0) return;
        w = -1;
        for (int k = 0; k < NREQ; k++)
            if (w < 0 && p[(ptr + k) % NREQ]) w = (ptr + k) % NREQ;
        who    = w;
        ptr    = (w + 1) % NREQ;
        g_tick = t;
        m_wr   = req_write[w];
        m_addr = req_addr[w*ADDR +: ADDR];
        m_data = req_wdata[w*DATA +: DATA];
        case (wait_mode)
            1:       slv_wait = $urandom_range(0, 3);
            2:       slv_wait = 1000;
            3:       slv_wait = 3;
            4:       slv_wait = TIMEOUT - 1;
            default: slv_wait = 0;
        endcase
        m_to      = slv_wait >= TIMEOUT;
        n_acc     = m_to ? TIMEOUT : slv_wait + 1;
        done_d    = n_acc + 2 + ((!m_wr && !m_to) ? 1 : 0);
        in_flight = 1;
    endtask

    // Memory slave: inserts planned wait states, returns read data one cycle after the access completes.
    task automatic slave();
        if (pend_rd) begin
            prdata  = slave_get(int'(rd_addr));
            pend_rd = 0;
        end else begin
            prdata = $urandom;
        end
        if (psel && penable) begin
            pready = (acc_cnt >= slv_wait);
            if (pready) begin
                if (pwrite) slave_mem[int'(paddr)] = pwdata;
                else begin
                    pend_rd = 1;
                    rd_addr = paddr;
                end
            end
            acc_cnt++;
        end else begin
            pready = 1'($urandom_range(0, 1));
            if (psel) acc_cnt = 0;
        end
    endtask

    function automatic bit any_remaining();
        for (int i = 0; i < NREQ; i++) if (remaining[i] > 0) return 1;
        return 0;
    endfunction

    task automatic run_batch(input logic [NREQ-1:0] mask, input int n, input int mode, input int stop);
        int steps;
        wait_mode = mode;
        for (int i = 0; i < NREQ; i++) remaining[i] = mask[i] ? n : 0;
        arm();
        grant();
        steps = 0;
        while (any_remaining() && (stop == 0 || steps < stop) && steps < 3000) begin
            tick();
            complete();
            arm();
            slave();
            grant();
            steps++;
        end
        if (stop == 0 && steps >= 3000) check("batch_budget", 0, 1);
    endtask

    initial begin
        preset_n  = 1'b0;
        req       = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        pready    = 1'b0;
        prdata    = '0;
        for (int i = 0; i < NREQ; i++) begin
            remaining[i]    = 0;
            dut_done_cnt[i] = 0;
        end
        repeat (2) @(negedge pclk);
        check("rst_psel", psel, 0);
        check("rst_penable", penable, 0);
        check("rst_pwrite", pwrite, 0);
        check("rst_paddr", paddr, 0);
        check("rst_pwdata", pwdata, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_rdata", rdata, 0);
        preset_n = 1'b1;

        ov_en   = 1;
        ov_wr   = 1;
        ov_addr = 10'h010;
        ov_data = 32'hA5;
        run_batch(4'b0001, 1, 0, 0);
        ov_wr = 0;
        run_batch(4'b0001, 1, 0, 0);
        check("read_back_a5", rdata, 32'hA5);
        ov_en = 0;

        for (int i = 0; i < NREQ; i++) dut_done_cnt[i] = 0;
        run_batch(4'b0011, 10, 0, 0);
        check("no_starve_0", dut_done_cnt[0], 10);
        check("no_starve_1", dut_done_cnt[1], 10);

        run_batch(4'b1111, 6, 1, 0);
        run_batch(4'b0100, 2, 3, 0);
        run_batch(4'b0010, 2, 4, 0);
        run_batch(4'b0001, 2, 2, 0);

        run_batch(4'b1000, 1, 0, 0);
        first_dut_done = -1;
        run_batch(4'b0101, 1, 0, 0);
        check("wrap_first_grant", first_dut_done, 0);

        run_batch(4'b0010, 1, 2, 2);
        preset_n = 1'b0;
        #1;
        check("mid_rst_psel", psel, 0);
        check("mid_rst_penable", penable, 0);
        check("mid_rst_pwrite", pwrite, 0);
        check("mid_rst_paddr", paddr, 0);
        check("mid_rst_pwdata", pwdata, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_rdata", rdata, 0);
        in_flight = 0;
        ptr       = 0;
        ref_rdata = '0;
        mdone     = '0;
        req       = '0;
        pend_rd   = 0;
        for (int i = 0; i < NREQ; i++) remaining[i] = 0;
        repeat (3) tick();
        preset_n = 1'b1;
        first_dut_done = -1;
        run_batch(4'b1001, 1, 0, 0);
        check("post_rst_first_grant", first_dut_done, 0);

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
